// File: rtl/dmem_req_bridge.sv
// Bridges the MEM-stage single-cycle data port onto a split req/addr_ok/data_ok bus.
// DataStallM holds the pipeline until the access completes; read data is held afterwards.
module dmem_req_bridge #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter bit ALIGN_READ = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemEnableM,
  input  logic [DATA_W/8-1:0]   MemWenM,
  input  logic [ADDR_W-1:0]     MemAddrM,
  input  logic [DATA_W-1:0]     TWriteDataM,
  input  logic                  ExceptDealM,
  input  logic                  StallM,
  output logic [DATA_W-1:0]     ReadDataM,
  output logic                  DataStallM,
  output logic                  data_req,
  output logic                  data_wr,
  output logic [DATA_W/8-1:0]   data_wstrb,
  output logic [ADDR_W-1:0]     data_addr,
  output logic [DATA_W-1:0]     data_wdata,
  input  logic                  data_addr_ok,
  input  logic                  data_data_ok,
  input  logic [DATA_W-1:0]     data_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_req;
  logic                  r_wr;
  logic [DATA_W/8-1:0]   r_wstrb;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W-1:0]     r_rdata;

  logic                  w_start;
  logic                  w_is_read;
  logic [ADDR_W-1:0]     w_req_addr;

  assign w_start   = MemEnableM & ~ExceptDealM;
  assign w_is_read = ~|MemWenM;
  // Reads fetch the whole word; the datapath picks the byte lanes it needs.
  assign w_req_addr = (ALIGN_READ && w_is_read) ? {MemAddrM[ADDR_W-1:2], 2'b00} : MemAddrM;

  always_comb begin
    w_state_next = r_state;
    DataStallM   = 1'b0;
    case (r_state)
      S_IDLE: begin
        DataStallM = w_start;
        if (w_start) w_state_next = S_REQ;
      end
      S_REQ: begin
        DataStallM = 1'b1;
        if (data_addr_ok) w_state_next = S_WAIT;
      end
      S_WAIT: begin
        DataStallM = 1'b1;
        if (data_data_ok) w_state_next = S_DONE;
      end
      S_DONE: begin
        // Stay here while another hazard holds MEM so the access is not reissued.
        if (!StallM) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req   <= 1'b0;
      r_wr    <= 1'b0;
      r_wstrb <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_req   <= 1'b1;
            r_wr    <= ~w_is_read;
            r_wstrb <= MemWenM;
            r_addr  <= w_req_addr;
            r_wdata <= TWriteDataM;
          end
        end
        S_REQ: begin
          if (data_addr_ok) r_req <= 1'b0;
        end
        S_WAIT: begin
          if (data_data_ok && !r_wr) r_rdata <= data_rdata;
        end
        default: ;
      endcase
    end
  end

  assign data_req   = r_req;
  assign data_wr    = r_wr;
  assign data_wstrb = r_wstrb;
  assign data_addr  = r_addr;
  assign data_wdata = r_wdata;
  assign ReadDataM  = r_rdata;

endmodule
